// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decodes the immediate format, sign-extends it to XLEN and
// precomputes pc+imm behind a valid/ready handshake with a two-entry (main + skid) buffer.
module imm_gen_stage #(
  parameter int unsigned XLEN    = 32,
  parameter bit          EN_RV64 = (XLEN == 64)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_pc_rel
);

  typedef enum logic [2:0] {
    FmtNone    = 3'd0,
    FmtI       = 3'd1,
    FmtS       = 3'd2,
    FmtB       = 3'd3,
    FmtU       = 3'd4,
    FmtJ       = 3'd5,
    FmtZ       = 3'd6,
    FmtIllegal = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic [XLEN-1:0] pc_rel;
  } entry_t;

  // RV64-only opcodes are never legal on a 32-bit datapath.
  localparam bit Rv64 = EN_RV64 && (XLEN == 64);

  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpOp32   = 7'b0111011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpMisc   = 7'b0001111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              is_shift;
  logic signed [11:0] raw_i, raw_s;
  logic signed [12:0] raw_b;
  logic signed [31:0] raw_u;
  logic signed [20:0] raw_j;
  logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j, imm_z, shamt_w, shamt_x;
  fmt_e              dec_fmt;
  logic [XLEN-1:0]   dec_imm;
  entry_t            new_entry;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign raw_i = in_instr[31:20];
  assign raw_s = {in_instr[31:25], in_instr[11:7]};
  assign raw_b = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign raw_u = {in_instr[31:12], 12'b0};
  assign raw_j = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  assign imm_i   = XLEN'(raw_i);
  assign imm_s   = XLEN'(raw_s);
  assign imm_b   = XLEN'(raw_b);
  assign imm_u   = XLEN'(raw_u);
  assign imm_j   = XLEN'(raw_j);
  assign imm_z   = XLEN'(in_instr[19:15]);
  assign shamt_w = XLEN'(in_instr[24:20]);
  // Full-width shifts carry a 6-bit shamt on RV64.
  assign shamt_x = (XLEN == 64) ? XLEN'(in_instr[25:20]) : shamt_w;

  always_comb begin
    dec_fmt = FmtIllegal;
    dec_imm = '0;
    unique case (opcode)
      OpOp: dec_fmt = FmtNone;
      OpOp32: begin
        if (Rv64) dec_fmt = FmtNone;
      end
      OpImm: begin
        dec_fmt = FmtI;
        dec_imm = is_shift ? shamt_x : imm_i;
      end
      OpImm32: begin
        if (Rv64) begin
          dec_fmt = FmtI;
          dec_imm = is_shift ? shamt_w : imm_i;
        end
      end
      OpLoad, OpJalr, OpMisc: begin
        dec_fmt = FmtI;
        dec_imm = imm_i;
      end
      OpStore: begin
        dec_fmt = FmtS;
        dec_imm = imm_s;
      end
      OpBranch: begin
        dec_fmt = FmtB;
        dec_imm = imm_b;
      end
      OpLui, OpAuipc: begin
        dec_fmt = FmtU;
        dec_imm = imm_u;
      end
      OpJal: begin
        dec_fmt = FmtJ;
        dec_imm = imm_j;
      end
      OpSystem: begin
        dec_fmt = funct3[2] ? FmtZ : FmtNone;
        dec_imm = funct3[2] ? imm_z : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    new_entry.instr  = in_instr;
    new_entry.pc     = in_pc;
    new_entry.imm    = dec_imm;
    new_entry.fmt    = dec_fmt;
    new_entry.pc_rel = in_pc + dec_imm;
  end

  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_ready) begin
      // Main is free this edge: refill from skid first, else straight from the input.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_valid) begin
        main_d       = new_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_valid && !skid_valid_q) begin
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready   = !skid_valid_q;
  assign out_valid  = main_valid_q;
  assign out_instr  = main_q.instr;
  assign out_pc     = main_q.pc;
  assign out_imm    = main_q.imm;
  assign out_fmt    = main_q.fmt;
  assign out_pc_rel = main_q.pc_rel;

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered, parametrised immediate-generation stage between instruction fetch and decode/execute.
- Classifies each instruction's immediate format and sign-extends the immediate to XLEN.
- Precomputes the PC-relative sum pc+imm.
- Runs behind a valid/ready handshake with a 2-entry skid buffer, so it sustains one instruction per cycle under backpressure. Supports synchronous flush for branch redirect.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
EN_RV64, (XLEN==64), enables OP-IMM-32/OP-32 opcodes; forced 0 when XLEN==32

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous kill of all buffered entries
in_valid  in  1  upstream has an instruction
in_ready  out  1  stage can accept this cycle
in_instr  in  32  raw instruction
in_pc  in  XLEN  instruction address
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts this cycle
out_instr  out  32  instruction passed through
out_pc  out  XLEN  pc passed through
out_imm  out  XLEN  extended immediate
out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 ILLEGAL
out_pc_rel  out  XLEN  out_pc + out_imm, modulo 2^XLEN

Behaviour:
- Reset (reset_n=0, asynchronous): both entries invalid; out_valid=0; in_ready=1; out_imm, out_pc, out_pc_rel, out_instr = 0; out_fmt=0. Reset release takes effect on the next clk edge.
- Decode by opcode = instr[6:0], all immediates sign-extended from instr[31] to XLEN:
  - 0110011 (R), and 0111011 when EN_RV64: NONE, imm=0.
  - 0010011 (OP-IMM), 0000011 (LOAD), 1100111 (JALR), 0001111 (MISC-MEM), and 0011011 when EN_RV64: I, imm={instr[31:20]}.
  - OP-IMM shifts (funct3 001/101): imm = zero-extended shamt, instr[24:20] for XLEN=32 or OP-IMM-32, instr[25:20] for XLEN=64.
  - 0100011: S, {instr[31:25],instr[11:7]}.
  - 1100011: B, {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - 0110111 (LUI) and 0010111 (AUIPC): U, {instr[31:12],12'b0}, sign-extended to XLEN when XLEN=64.
  - 1101111: J, {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - 1110011 with funct3[2]=1: Z, imm = zero-extended instr[19:15]. With funct3[2]=0: NONE, imm=0.
  - Any other opcode, including RV64 opcodes when EN_RV64=0: ILLEGAL, imm=0. ILLEGAL instructions still flow through the stage.
- out_pc_rel is always computed; it is only meaningful for B, J and U/AUIPC.
- Handshake:
  - A transfer occurs on the edge where valid&&ready is high on the same side.
  - Latency: an instruction accepted at edge N appears on out_* after edge N (1 cycle) when the output is empty or drains at N.
- Buffer: a main output register plus one skid register.
  - in_ready = !skid_valid. in_ready is registered and depends only on state, never on out_ready.
  - Output stalled (out_valid && !out_ready) and input accepted: the new entry goes to skid.
  - Output drains while skid is full: skid moves to main. A simultaneous input is impossible because in_ready=0.
  - Output drains, skid is empty, input accepted: the new entry goes straight to main.
  - Output drains with no input: out_valid drops.
  - Ordering is strictly FIFO; no entry is duplicated or dropped.
- out_* hold stable while out_valid && !out_ready.
- Flush:
  - Next edge: main and skid invalid; any in_valid presented that cycle is discarded.
  - out_valid=0 and in_ready=1 after the edge.
  - flush has priority over every other event.
- Arithmetic: immediate decode and pc+imm are done before capture. The add is XLEN-bit and wraps with no overflow flag.

Test Plan:
- XLEN=32: in_pc=0x0, in_instr=0xFFF00093 (addi x1,x0,-1) -> out_fmt=1, out_imm=0xFFFFFFFF; out_valid rises 1 cycle after acceptance.
- in_instr=0x12345037 (lui) -> fmt=4, imm=0x12345000. in_pc=0x100, in_instr=0x0080006F (jal x0,8) -> fmt=5, imm=0x8, pc_rel=0x108. in_pc=0x0, in_instr=0xFE000EE3 (beq -4) -> fmt=3, imm=0xFFFFFFFC, pc_rel=0xFFFFFFFC (wrap).
- Back-to-back stream of 4 instructions with out_ready=0 for 3 cycles -> in_ready=0 after 2 accepted; after release, outputs emerge in order, one per cycle, with stable hold while stalled.
- flush asserted with main and skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the discarded instruction never appears.
- XLEN=64: in_instr=0x0010009B (addiw x1,x0,1) -> fmt=1, imm=1; in_instr=0x80000037 (lui) -> imm=0xFFFFFFFF80000000. XLEN=32 with the same addiw -> fmt=7. 0x4010D093 (srai shamt=1) -> imm=1.
- reset_n pulled low mid-stream between clock edges -> out_valid=0 immediately; in_ready=1; no stale entry after release.
